// File: rtl/antares_port_arbiter.sv
// antares_port_arbiter: round-robin arbiter that serialises the core's
// instruction port (iport) and data port (dport) onto one shared slave port.
// A granted transfer is held until the slave completes it. A watchdog can
// abort a transfer that is never acknowledged and report an error instead.
module antares_port_arbiter #(
   parameter int TIMEOUT   = 1023,
   parameter int CNT_WIDTH = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iport_address,
   input  logic [3:0]  iport_wr,
   input  logic        iport_enable,
   output logic [31:0] iport_data_i,
   output logic        iport_ready,
   output logic        iport_error,
   input  logic [31:0] dport_address,
   input  logic [31:0] dport_data_o,
   input  logic [3:0]  dport_wr,
   input  logic        dport_enable,
   output logic [31:0] dport_data_i,
   output logic        dport_ready,
   output logic        dport_error,
   output logic [31:0] m_address,
   output logic [31:0] m_data_o,
   output logic [3:0]  m_wr,
   output logic        m_enable,
   input  logic [31:0] m_data_i,
   input  logic        m_ready,
   input  logic        m_error
);

   typedef enum logic [1:0] {
      IDLE,
      GNT_I,
      GNT_D
   } state_t;

   // Counter value at which the watchdog gives up; 0 keeps the compare harmless
   // because the watchdog is disabled entirely when TIMEOUT is 0.
   localparam logic [CNT_WIDTH-1:0] LP_LIMIT = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] LP_MAX   = '1;

   state_t                r_state;
   state_t                w_nextState;
   logic                  r_lastDport;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  w_granted;
   logic                  w_timeout;
   logic                  w_done;

   // Read data is broadcast to both ports; only the matching ready qualifies it.
   assign iport_data_i = m_data_i;
   assign dport_data_i = m_data_i;

   // A transfer ends either by slave acknowledge or by watchdog expiry.
   assign w_granted = (r_state != IDLE);
   assign w_timeout = (TIMEOUT != 0) && w_granted && !m_ready && (r_count == LP_LIMIT);
   assign w_done    = w_granted && (m_ready || w_timeout);

   // State, last-grant and watchdog registers; reset abandons any transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_lastDport <= 1'b0;
         r_count     <= '0;
      end else begin
         r_state <= w_nextState;
         if ((w_nextState != r_state) && (w_nextState != IDLE)) begin
            r_lastDport <= (w_nextState == GNT_D);
         end
         if ((w_nextState != r_state) || !w_granted) begin
            r_count <= '0;
         end else if (r_count != LP_MAX) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // Next-state selection plus the shared-port mux and per-port completion.
   // After a completion only the other port may be granted directly, since the
   // finished port's enable can still be stale on that edge.
   always_comb begin
      w_nextState = r_state;
      m_enable    = 1'b0;
      m_address   = '0;
      m_wr        = '0;
      m_data_o    = '0;
      iport_ready = 1'b0;
      iport_error = 1'b0;
      dport_ready = 1'b0;
      dport_error = 1'b0;
      case (r_state)
         IDLE: begin
            if (iport_enable && dport_enable) begin
               w_nextState = r_lastDport ? GNT_I : GNT_D;
            end else if (iport_enable) begin
               w_nextState = GNT_I;
            end else if (dport_enable) begin
               w_nextState = GNT_D;
            end
         end
         GNT_I: begin
            m_enable    = !w_timeout;
            m_address   = iport_address;
            m_wr        = iport_wr;
            iport_ready = w_done;
            iport_error = w_timeout || (m_ready && m_error);
            if (w_done) begin
               w_nextState = dport_enable ? GNT_D : IDLE;
            end
         end
         GNT_D: begin
            m_enable    = !w_timeout;
            m_address   = dport_address;
            m_wr        = dport_wr;
            m_data_o    = dport_data_o;
            dport_ready = w_done;
            dport_error = w_timeout || (m_ready && m_error);
            if (w_done) begin
               w_nextState = iport_enable ? GNT_I : IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

endmodule

// File: doc/antares_port_arbiter.md
# antares_port_arbiter

Two-master to one-slave bus arbiter placed between the core's instruction port (iport) and data port (dport) and a single-ported memory or bus slave. It serialises the two port request streams onto one shared memory port. Contention is resolved round-robin, and transfers stay atomic from grant to ready. A watchdog terminates any transfer the slave never acknowledges, returning an error to the requesting port.

## Interface
- TIMEOUT, 1023 — cycles a granted transfer may wait for m_ready before abort; 0 disables the watchdog.
- CNT_WIDTH, 10 — watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT.

- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- iport_address  in  32  instruction request address.
- iport_wr  in  4  byte write strobes (0 = read).
- iport_enable  in  1  instruction request valid.
- iport_data_i  out  32  read data to instruction port.
- iport_ready  out  1  instruction transfer complete (1-cycle pulse).
- iport_error  out  1  qualifies iport_ready; bus error or timeout.
- dport_address  in  32  data request address.
- dport_data_o  in  32  data write data.
- dport_wr  in  4  byte write strobes.
- dport_enable  in  1  data request valid.
- dport_data_i  out  32  read data to data port.
- dport_ready  out  1  data transfer complete (1-cycle pulse).
- dport_error  out  1  qualifies dport_ready.
- m_address  out  32  shared port address.
- m_data_o  out  32  shared port write data (32'h0 when iport granted).
- m_wr  out  4  shared port strobes.
- m_enable  out  1  shared port request valid.
- m_data_i  in  32  slave read data.
- m_ready  in  1  slave completion, one cycle.
- m_error  in  1  slave error, qualifies m_ready.

## Operation
- Master rule: a port holds enable, address, wr and data stable from assertion until the cycle its ready is high.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - only one enable high → grant that port next edge.
  - both high → grant the port not granted last; last-grant register resets to "iport", so first contention goes to dport.
- GNT_x:
  - m_enable=1; m_address/m_wr/m_data_o muxed combinationally from the granted port.
  - watchdog counts from 0 each cycle m_ready is low.
- Completion (m_ready=1 in GNT_x):
  - x_ready=1 and x_error=m_error, same cycle, combinational.
  - next edge: if the other port's enable is high, grant it directly; else go IDLE.
  - The completed port is never re-granted without passing through IDLE, because its enable may still be stale on that edge.
- Timeout (counter == TIMEOUT-1 and m_ready=0, TIMEOUT≠0):
  - x_ready=1 and x_error=1 that cycle; m_enable forced 0 that cycle.
  - state transition identical to normal completion.
- Read data: iport_data_i = dport_data_i = m_data_i always; qualified only by the respective ready.
- Ready/error outputs of the non-granted port are always 0.
- m_ready while IDLE: ignored.

## Timing
- Reset values:
  - state IDLE, last-grant iport, counter 0.
  - all ready/error 0; m_enable 0.
  - m_address/m_wr/m_data_o 0.
- Reset mid-transfer: the transfer is abandoned asynchronously. m_enable drops immediately and no ready is issued.
- Latency with an idle arbiter:
  - request seen at edge t, m_enable high in cycle t+1.
  - single-cycle slave → ready in t+1.
- Back-to-back alternating ports: no bubble.
- Same port repeated: one IDLE cycle between transfers.
- Simultaneous completion and new request from the other port: handled by the direct handoff.
- Counter width: CNT_WIDTH bits, saturating; cleared on every grant.

## Test plan
- Reset with both enables high → all outputs 0. Release rst; dport_enable=1 and iport_enable=1 with a 1-cycle slave → dport_ready at cycle 1, iport_ready at cycle 2, no IDLE cycle between.
- iport alone, 4 consecutive reads to 0x00000000/4/8/C, slave returning address+1 → each iport_data_i correct; IDLE cycle between grants; dport_ready stays 0.
- dport write with dport_wr=4'b0011, dport_data_o=0xDEADBEEF, 3-cycle slave → m_wr=0011 and m_data_o=0xDEADBEEF held stable for 3 cycles; single dport_ready pulse.
- TIMEOUT=8, slave never ready → m_enable high for cycles 1..7, dport_ready=dport_error=1 in cycle 8, then arbiter returns to IDLE.
- m_error=1 with m_ready on an iport read → iport_error=1 for exactly that cycle; next transfer's error=0.
- rst pulled low during cycle 2 of a 5-cycle slave transfer → m_enable falls immediately, no ready. After release, a pending dport request is granted normally.
